// File: rtl/axil_req_arbiter.sv
// Round-robin arbiter that lets N simple register requesters share one
// AXI4-Lite master port, one single-beat read or write at a time.
module axil_req_arbiter #(
    parameter int N      = 2,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  axi_clk,
    input  logic                  axi_rst,
    input  logic [N-1:0]          req_valid,
    input  logic [N-1:0]          req_we,
    input  logic [N*ADDR_W-1:0]   req_addr,
    input  logic [N*DATA_W-1:0]   req_wdata,
    output logic [N-1:0]          req_ready,
    output logic [N-1:0]          rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  m_awvalid,
    output logic [ADDR_W-1:0]     m_awaddr,
    input  logic                  m_awready,
    output logic                  m_wvalid,
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  m_wready,
    input  logic                  m_bvalid,
    input  logic [1:0]            m_bresp,
    output logic                  m_bready,
    output logic                  m_arvalid,
    output logic [ADDR_W-1:0]     m_araddr,
    input  logic                  m_arready,
    input  logic                  m_rvalid,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    output logic                  m_rready
);

    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WADDR,
        S_WRESP,
        S_RADDR,
        S_RDATA,
        S_RSP
    } state_t;

    state_t              r_state;
    logic [PTR_W-1:0]    r_ptr;
    logic [PTR_W-1:0]    r_grant;
    logic                r_awvalid;
    logic                r_wvalid;
    logic                r_bready;
    logic                r_arvalid;
    logic                r_rready;
    logic [ADDR_W-1:0]   r_awaddr;
    logic [ADDR_W-1:0]   r_araddr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err;
    logic [N-1:0]        r_rsp_valid;

    logic                w_found;
    logic [PTR_W-1:0]    w_pick;
    logic [PTR_W-1:0]    w_ptr_next;
    logic [N-1:0]        w_ready;
    logic [N-1:0]        w_grant_oh;
    logic                w_aw_done;
    logic                w_w_done;

    // Pick the first asserted request at or above the pointer, wrapping around.
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(r_ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_pick  = PTR_W'(idx);
            end
        end
    end

    // Accept is offered only while idle, and only to the chosen requester.
    always_comb begin
        w_ready = '0;
        if (r_state == S_IDLE && w_found) w_ready[w_pick] = 1'b1;
    end

    // One-hot form of the latched grant, used for the completion pulse.
    always_comb begin
        w_grant_oh = '0;
        for (int k = 0; k < N; k++) begin
            w_grant_oh[k] = (r_grant == PTR_W'(k));
        end
    end

    assign w_ptr_next = (w_pick == PTR_W'(N - 1)) ? '0 : w_pick + PTR_W'(1);
    assign w_aw_done  = !r_awvalid || m_awready;
    assign w_w_done   = !r_wvalid  || m_wready;

    // Transaction sequencer: arbitration, AXI handshakes and response pulse.
    always_ff @(posedge axi_clk) begin
        if (axi_rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_awaddr    <= '0;
            r_araddr    <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            r_rsp_valid <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_pick;
                        r_ptr   <= w_ptr_next;
                        r_err   <= 1'b0;
                        r_rdata <= '0;
                        if (req_we[w_pick]) begin
                            r_awaddr  <= req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
                            r_wdata   <= req_wdata[int'(w_pick)*DATA_W +: DATA_W];
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= S_WADDR;
                        end else begin
                            r_araddr  <= req_addr[int'(w_pick)*ADDR_W +: ADDR_W];
                            r_arvalid <= 1'b1;
                            r_state   <= S_RADDR;
                        end
                    end
                end
                S_WADDR: begin
                    if (r_awvalid && m_awready) r_awvalid <= 1'b0;
                    if (r_wvalid && m_wready)   r_wvalid  <= 1'b0;
                    if (w_aw_done && w_w_done) begin
                        r_bready <= 1'b1;
                        r_state  <= S_WRESP;
                    end
                end
                S_WRESP: begin
                    if (m_bvalid) begin
                        r_bready    <= 1'b0;
                        r_err       <= (m_bresp != 2'b00);
                        r_rsp_valid <= w_grant_oh;
                        r_state     <= S_RSP;
                    end
                end
                S_RADDR: begin
                    if (m_arready) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_RDATA;
                    end
                end
                S_RDATA: begin
                    if (m_rvalid) begin
                        r_rready    <= 1'b0;
                        r_rdata     <= m_rdata;
                        r_err       <= (m_rresp != 2'b00);
                        r_rsp_valid <= w_grant_oh;
                        r_state     <= S_RSP;
                    end
                end
                S_RSP: begin
                    r_rsp_valid <= '0;
                    r_rdata     <= '0;
                    r_err       <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready = w_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign m_awvalid = r_awvalid;
    assign m_awaddr  = r_awaddr;
    assign m_wvalid  = r_wvalid;
    assign m_wdata   = r_wdata;
    assign m_wstrb   = '1;
    assign m_bready  = r_bready;
    assign m_arvalid = r_arvalid;
    assign m_araddr  = r_araddr;
    assign m_rready  = r_rready;

endmodule

// File: tb/tb_axil_req_arbiter.sv
// Scoreboard bench for axil_req_arbiter: directed requests, a delay-programmable
// AXI4-Lite slave, and a monitor that checks every response pulse.
module tb_axil_req_arbiter;

    localparam int N = 2;
    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            axi_rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_we = '0;
    logic [N*AW-1:0] req_addr = '0;
    logic [N*DW-1:0] req_wdata = '0;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            m_awvalid;
    logic [AW-1:0]   m_awaddr;
    logic            m_awready = 1'b0;
    logic            m_wvalid;
    logic [DW-1:0]   m_wdata;
    logic [DW/8-1:0] m_wstrb;
    logic            m_wready = 1'b0;
    logic            m_bvalid = 1'b0;
    logic [1:0]      m_bresp = 2'b00;
    logic            m_bready;
    logic            m_arvalid;
    logic [AW-1:0]   m_araddr;
    logic            m_arready = 1'b0;
    logic            m_rvalid = 1'b0;
    logic [DW-1:0]   m_rdata = '0;
    logic [1:0]      m_rresp = 2'b00;
    logic            m_rready;

    typedef struct {
        logic [N-1:0]  oh;
        logic [DW-1:0] rdata;
        logic          err;
    } exp_t;

    exp_t expQ[$];
    int   testsRun = 0;
    int   testsFailed = 0;

    // slave configuration and state
    int          awDelay = 0, wDelay = 0, bDelay = 0, arDelay = 0, rDelay = 0;
    logic [31:0] sRdata = '0;
    logic [1:0]  sRresp = 2'b00, sBresp = 2'b00;
    int          awCnt = 0, wCnt = 0, bCnt = 0, arCnt = 0, rCnt = 0;
    bit          awDone = 0, wDone = 0, arDone = 0;
    int          bHsCount = 0;

    axil_req_arbiter #(.N(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .axi_clk   (clk),
        .axi_rst   (axi_rst),
        .req_valid (req_valid),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .m_awvalid (m_awvalid),
        .m_awaddr  (m_awaddr),
        .m_awready (m_awready),
        .m_wvalid  (m_wvalid),
        .m_wdata   (m_wdata),
        .m_wstrb   (m_wstrb),
        .m_wready  (m_wready),
        .m_bvalid  (m_bvalid),
        .m_bresp   (m_bresp),
        .m_bready  (m_bready),
        .m_arvalid (m_arvalid),
        .m_araddr  (m_araddr),
        .m_arready (m_arready),
        .m_rvalid  (m_rvalid),
        .m_rdata   (m_rdata),
        .m_rresp   (m_rresp),
        .m_rready  (m_rready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    // Slave model: readies and responses change on the falling edge; a ready
    // still high one edge later means its handshake happened at the rising edge.
    always @(negedge clk) begin
        if (axi_rst) begin
            m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
            awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0;
            awDone = 0; wDone = 0; arDone = 0;
        end else begin
            if (m_awready) begin
                m_awready = 0; awCnt = 0; awDone = 1;
            end else if (m_awvalid) begin
                if (awCnt >= awDelay) m_awready = 1; else awCnt++;
            end
            if (m_wready) begin
                m_wready = 0; wCnt = 0; wDone = 1;
            end else if (m_wvalid) begin
                if (wCnt >= wDelay) m_wready = 1; else wCnt++;
            end
            if (m_bvalid) begin
                m_bvalid = 0; bHsCount++;
            end else if (awDone && wDone) begin
                if (bCnt >= bDelay) begin
                    m_bvalid = 1; m_bresp = sBresp; awDone = 0; wDone = 0; bCnt = 0;
                end else bCnt++;
            end
            if (m_arready) begin
                m_arready = 0; arCnt = 0; arDone = 1;
            end else if (m_arvalid) begin
                if (arCnt >= arDelay) m_arready = 1; else arCnt++;
            end
            if (m_rvalid) begin
                m_rvalid = 0;
            end else if (arDone) begin
                if (rCnt >= rDelay) begin
                    m_rvalid = 1; m_rdata = sRdata; m_rresp = sRresp; arDone = 0; rCnt = 0;
                end else rCnt++;
            end
        end
    end

    // Monitor: every response pulse must match the oldest expected response.
    always @(negedge clk) begin
        if (rsp_valid != '0) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpectedRsp", 64'(rsp_valid), 64'(0));
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("rspGrant", 64'(rsp_valid), 64'(e.oh));
                checkOutput("rspRdata", 64'(rsp_rdata), 64'(e.rdata));
                checkOutput("rspErr", 64'(rsp_err), 64'(e.err));
            end
        end
    end

    // Called on a falling edge; returns on the falling edge of the cycle after accept.
    task automatic applyStimulus(input int idx, input bit we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] expRdata,
                                 input bit expErr, output bit ok);
        exp_t e;
        ok = 0;
        req_we[idx] = we;
        req_addr[idx*AW +: AW] = addr;
        req_wdata[idx*DW +: DW] = wdata;
        req_valid[idx] = 1'b1;
        for (int c = 0; c < 60 && !ok; c++) begin
            #1;
            if (req_ready[idx]) ok = 1;
            else @(negedge clk);
        end
        if (!ok) begin
            checkOutput("acceptTimeout", 64'(req_ready), 64'(1 << idx));
        end else begin
            e.oh = N'(1 << idx);
            e.rdata = expRdata;
            e.err = expErr;
            expQ.push_back(e);
        end
        @(negedge clk);
        req_valid[idx] = 1'b0;
    endtask

    task automatic waitIdle();
        for (int c = 0; c < 100 && expQ.size() != 0; c++) @(negedge clk);
        checkOutput("drainTimeout", 64'(expQ.size()), 64'(0));
        @(negedge clk);
    endtask

    task automatic pulseReset();
        axi_rst = 1'b1;
        repeat (2) @(negedge clk);
        axi_rst = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "Ctrl"},
            64'({m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready, rsp_valid, rsp_err, req_ready}), 64'(0));
        checkOutput({tag, "Awaddr"}, 64'(m_awaddr), 64'(0));
        checkOutput({tag, "Araddr"}, 64'(m_araddr), 64'(0));
        checkOutput({tag, "Wdata"}, 64'(m_wdata), 64'(0));
        checkOutput({tag, "Rdata"}, 64'(rsp_rdata), 64'(0));
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit ok;
        int bBefore;
        repeat (3) @(negedge clk);
        checkResetOutputs("reset");
        axi_rst = 1'b0;
        @(negedge clk);

        // single zero-wait write from requester 0
        awDelay = 0; wDelay = 0; bDelay = 0; sBresp = 2'b00;
        applyStimulus(0, 1, 32'h10, 32'hDEADBEEF, 32'h0, 0, ok);
        checkOutput("wrAwvalidT1", 64'({m_awvalid, m_wvalid}), 64'(2'b11));
        checkOutput("wrAwaddrT1", 64'(m_awaddr), 64'h10);
        checkOutput("wrWdataT1", 64'(m_wdata), 64'hDEADBEEF);
        checkOutput("wrWstrb", 64'(m_wstrb), 64'hF);
        @(negedge clk);
        checkOutput("wrBreadyT2", 64'(m_bready), 64'(1));
        @(negedge clk);
        checkOutput("wrRspT3", 64'(rsp_valid), 64'(2'b01));
        waitIdle();

        // read from requester 1 with arready delayed 3 and rvalid delayed 2, SLVERR
        arDelay = 3; rDelay = 2; sRdata = 32'h12345678; sRresp = 2'b10;
        applyStimulus(1, 0, 32'h24, 32'h0, 32'h12345678, 1, ok);
        for (int k = 0; k < 4; k++) begin
            checkOutput("rdArHold", 64'({m_arvalid, m_araddr}), {31'd0, 1'b1, 32'h24});
            @(negedge clk);
        end
        checkOutput("rdArDrop", 64'(m_arvalid), 64'(0));
        checkOutput("rdRready", 64'(m_rready), 64'(1));
        repeat (3) @(negedge clk);
        checkOutput("rdRspT8", 64'(rsp_valid), 64'(2'b10));
        waitIdle();

        // fairness: both requesters hold continuous reads after a fresh reset
        pulseReset();
        arDelay = 0; rDelay = 0; sRdata = 32'h0BADF00D; sRresp = 2'b00;
        req_we = '0;
        req_addr = {32'h200, 32'h100};
        req_valid = 2'b11;
        for (int g = 0; g < 6; g++) begin
            bit found;
            logic [N-1:0] want;
            exp_t e;
            found = 0;
            want = (g % 2 == 0) ? 2'b01 : 2'b10;
            for (int c = 0; c < 60 && !found; c++) begin
                #1;
                if (req_ready != '0) found = 1;
                else @(negedge clk);
            end
            checkOutput("fairGrant", 64'(req_ready), 64'(want));
            e.oh = want; e.rdata = 32'h0BADF00D; e.err = 0;
            if (found) expQ.push_back(e);
            @(negedge clk);
        end
        req_valid = '0;
        waitIdle();

        // split write channels: wready 4 cycles before awready
        awDelay = 4; wDelay = 0; bDelay = 0; sBresp = 2'b00;
        bBefore = bHsCount;
        applyStimulus(0, 1, 32'h40, 32'h00005A5A, 32'h0, 0, ok);
        checkOutput("splitBothT1", 64'({m_awvalid, m_wvalid}), 64'(2'b11));
        @(negedge clk);
        checkOutput("splitT2", 64'({m_awvalid, m_wvalid, m_bready}), 64'(3'b100));
        repeat (3) @(negedge clk);
        checkOutput("splitT5", 64'({m_awvalid, m_wvalid, m_bready}), 64'(3'b100));
        @(negedge clk);
        checkOutput("splitT6", 64'({m_awvalid, m_wvalid, m_bready}), 64'(3'b001));
        @(negedge clk);
        checkOutput("splitRspT7", 64'(rsp_valid), 64'(2'b01));
        waitIdle();
        checkOutput("splitBCount", 64'(bHsCount - bBefore), 64'(1));

        // reset while waiting in the read data phase
        awDelay = 0; arDelay = 0; rDelay = 20; sRdata = 32'hFFFF0000;
        req_we[1] = 1'b0;
        req_addr[AW +: AW] = 32'h30;
        req_valid[1] = 1'b1;
        ok = 0;
        for (int c = 0; c < 60 && !ok; c++) begin
            #1;
            if (req_ready[1]) ok = 1;
            else @(negedge clk);
        end
        checkOutput("abortAccept", 64'(ok), 64'(1));
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        checkOutput("abortInRdata", 64'(m_rready), 64'(1));
        @(negedge clk);
        axi_rst = 1'b1;
        @(negedge clk);
        checkResetOutputs("abort");
        @(negedge clk);
        axi_rst = 1'b0;
        rDelay = 0;

        // fresh read from requester 1 after the abort
        sRdata = 32'hCAFEF00D; sRresp = 2'b00;
        applyStimulus(1, 0, 32'h30, 32'h0, 32'hCAFEF00D, 0, ok);
        checkOutput("freshAraddr", 64'({m_arvalid, m_araddr}), {31'd0, 1'b1, 32'h30});
        repeat (2) @(negedge clk);
        checkOutput("freshRspT3", 64'(rsp_valid), 64'(2'b10));
        waitIdle();

        checkOutput("pendingRsp", 64'(expQ.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
